muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the EX-stage forwarding operand muxes. It consumes the two forwarded operands, runs a fixed-latency shift-add multiply or restoring divide, and holds the result until the next accepted operation. While an operation is in flight, `busy` stalls the pipeline front end.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a new operation; sampled only in IDLE.
- `op`  input  2  operation: 00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder).
- `src_a`  input  32  operand A (multiplicand/dividend), taken from the forwarding mux output.
- `src_b`  input  32  operand B (multiplier/divisor), taken from the forwarding mux output.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  output  32  final result; holds its value until the next `done`.

## Operation
- States:
  - IDLE: `start`=1 captures `op`, `src_a`, `src_b`, clears the step counter, and moves to RUN.
  - RUN: performs one iteration per cycle. When the counter reaches 31, moves to DONE.
  - DONE: registers `result`, drives `done`=1, and returns to IDLE.
- `start` is ignored in RUN and DONE. The request is not queued.
- Operands are latched at accept; later changes on `src_a`/`src_b` have no effect.
- Multiply: shift-add into a 64-bit product register. MUL returns product[31:0]; MULH returns product[63:32].
- Divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- Divide by zero (no early exit; latency unchanged):
  - DIV returns 0xFFFFFFFF.
  - REM returns `src_a`.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.

## Timing
- Accept edge = cycle 0.
- `busy`=1 from cycle 1 through cycle 33 inclusive.
- RUN lasts 32 cycles (cycles 1–32).
- DONE is cycle 33: `done`=1 and `result` valid.
- Cycle 34: IDLE, `busy`=0. A new `start` can be accepted at the cycle-34 edge.
- Latency is fixed at 33 cycles for every op and operand value.
- The external stall condition is `start | busy`, so the issuing instruction stalls from its accept cycle.
- `rst` asserted at any point, including mid-RUN:
  - All outputs immediately take their reset values.
  - The in-flight operation is discarded.
  - No `done` pulse is produced for it.
- `start` together with `rst`: reset wins.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - Operands are two's-complement. MULH is signed×signed; DIV/REM are signed.
  - The unit works on magnitudes and applies sign correction when entering DONE. Latency is unchanged.
  - Quotient sign = sign(A) XOR sign(B); remainder takes the sign of A.
  - Overflow case 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
  - Divide by zero behaves as in Operation.
- `MULDIV_SIGNED_EN` not defined: all ops are unsigned (MULH = MULHU, DIV = DIVU, REM = REMU), and no sign logic is generated.

## Test plan
- MUL: A=7, B=6, `start` at cycle 0.
  - Required: `busy` high cycles 1–33, `done` only at cycle 33, `result`=42.
  - `result` still 42 ten cycles later.
- MULH: A=B=0xFFFFFFFF.
  - Unsigned build: `result`=0xFFFFFFFE.
  - Signed build: `result`=0x00000000 (−1×−1).
- DIV then REM, A=100, B=7.
  - Required: results 14 and 2.
  - Second `start` at cycle 34 is accepted, with `done` at cycle 67.
- Divide by zero, A=0x12345678, B=0.
  - Required: DIV returns 0xFFFFFFFF, REM returns 0x12345678, `done` still at cycle 33.
- `start` pulsed with different operands at cycles 5 and 33 during an operation.
  - Required: both ignored; exactly one `done`, carrying the original result.
- `rst` asserted for 1 cycle at cycle 10 of a DIV.
  - Required: `busy`, `done` and `result` go to 0 immediately; no `done` follows.
  - A fresh MUL 3×5 started afterwards returns 15 after 33 cycles.
- Signed build only:
  - DIV −7/2 returns 0xFFFFFFFD; REM −7/2 returns 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF returns 0x80000000.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit shift-add multiply / restoring divide; fixed 33-cycle latency, busy stalls issue.
// No backpressure on result: done pulses once; `MULDIV_SIGNED_EN enables two's-complement operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic [WIDTH-1:0]     a_in, b_in;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_step;
  logic [WIDTH:0]       rem_shift, rem_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_step, quo_step;
  logic [2*WIDTH-1:0]   prod_fin;
  logic [WIDTH-1:0]     quo_fin, rem_fin;

`ifdef MULDIV_SIGNED_EN
  logic a_neg_q, a_neg_d;
  logic b_neg_q, b_neg_d;

  // Datapath runs on magnitudes; signs are kept aside and reapplied on the final step.
  assign a_in = src_a[WIDTH-1] ? -src_a : src_a;
  assign b_in = src_b[WIDTH-1] ? -src_b : src_b;
`else
  assign a_in = src_a;
  assign b_in = src_b;
`endif

  // One multiply step and one divide step are evaluated every cycle; op selects which is used.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    div_ge    = ~rem_diff[WIDTH];
    rem_step  = div_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod_fin = (a_neg_q ^ b_neg_q) ? -prod_step : prod_step;
    if (b_q == '0) begin
      quo_fin = '1;
    end else begin
      quo_fin = (a_neg_q ^ b_neg_q) ? -quo_step : quo_step;
    end
    rem_fin = a_neg_q ? -rem_step : rem_step;
`else
    prod_fin = prod_step;
    quo_fin  = quo_step;
    rem_fin  = rem_step;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
`ifdef MULDIV_SIGNED_EN
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          prod_d  = {{WIDTH{1'b0}}, b_in};
          rem_d   = '0;
          quo_d   = a_in;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MULDIV_SIGNED_EN
          a_neg_d = src_a[WIDTH-1];
          b_neg_d = src_b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        prod_d = prod_step;
        rem_d  = rem_step;
        quo_d  = quo_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:  result_d = prod_fin[WIDTH-1:0];
            OP_MULH: result_d = prod_fin[2*WIDTH-1:WIDTH];
            OP_DIV:  result_d = quo_fin;
            OP_REM:  result_d = rem_fin;
            default: result_d = result_q;
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
`ifdef MULDIV_SIGNED_EN
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
`ifdef MULDIV_SIGNED_EN
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
`endif
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
